// File: rtl/async_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// async_fifo_wr_arbiter
//
// Shares the single write port of an async FIFO among NREQ packet sources.
// Ownership of the port changes only at packet boundaries, using round-robin
// order, so every packet lands contiguously in the FIFO. All logic runs in the
// FIFO write clock domain.
//
// Ports:
//   wclk          write-domain clock (same clock as the FIFO wclk)
//   wrst          asynchronous active-high reset
//   req_valid     per-requester beat valid
//   req_ready     per-requester beat accepted (only the owner can see ready)
//   req_data      packed beat data, requester k at [k*DSIZE +: DSIZE]
//   req_last      per-requester final-beat marker
//   winc          FIFO write enable
//   wdata         FIFO write data
//   wfull         FIFO full flag
//   awfull        FIFO almost-full flag (one free slot or fewer)
//   grant         one-hot registered owner, zero while idle
//   busy          high while a packet transfer is in progress
//   pkt_done_cnt  completed-packet counter, wraps modulo 2^CNTW
// -----------------------------------------------------------------------------
module async_fifo_wr_arbiter #(
    parameter int DSIZE = 32,
    parameter int NREQ  = 4,
    parameter int CNTW  = 16
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    input  logic                  wfull,
    input  logic                  awfull,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic [CNTW-1:0]       pkt_done_cnt
);

    localparam int              PTRW     = $clog2(NREQ);
    localparam logic [PTRW-1:0] LAST_IDX = PTRW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Registered state
    state_t          r_state;
    logic [NREQ-1:0] r_grant;
    logic [PTRW-1:0] r_owner;    // binary form of r_grant, used for the pointer update
    logic [PTRW-1:0] r_ptr;      // highest-priority requester for the next arbitration
    logic            r_busy;
    logic [CNTW-1:0] r_pkt_cnt;

    // Combinational helpers
    logic            w_win_found;
    logic [PTRW-1:0] w_win_idx;
    logic            w_start;
    logic            w_owner_valid;
    logic            w_owner_last;
    logic            w_write;
    logic            w_last_beat;
    logic [DSIZE-1:0] w_wdata;

    // Index increment modulo NREQ (NREQ need not be a power of two).
    function automatic logic [PTRW-1:0] wrap_inc(input logic [PTRW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // Round-robin search: first valid requester at or after r_ptr, wrapping.
    // -------------------------------------------------------------------------
    always_comb begin : rr_search
        logic [PTRW-1:0] cand;
        // NOTE: every signal assigned in a combinational block gets a default
        // before any conditional assignment, otherwise a latch is inferred.
        w_win_found = 1'b0;
        w_win_idx   = r_ptr;
        cand        = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (!w_win_found && req_valid[cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    // A new packet may start only from IDLE and only with room to spare.
    assign w_start = (r_state == ST_IDLE) && w_win_found && !awfull;

    // -------------------------------------------------------------------------
    // Owner mux. r_grant is zero outside XFER, so every term below is
    // naturally inactive while idle or in reset. Written as AND-OR so the
    // data path needs no binary decode of the owner.
    // -------------------------------------------------------------------------
    always_comb begin : owner_mux
        w_wdata = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_grant[k]) begin
                w_wdata = w_wdata | req_data[k*DSIZE +: DSIZE];
            end
        end
    end

    assign w_owner_valid = |(req_valid & r_grant);
    assign w_owner_last  = |(req_last  & r_grant);

    // wfull gates both sides of the handshake: no write into a full FIFO,
    // and the owner is told to hold its beat.
    assign w_write     = w_owner_valid && !wfull;
    assign w_last_beat = w_write && w_owner_last;

    assign req_ready    = wfull ? '0 : r_grant;
    assign winc         = w_write;
    assign wdata        = w_wdata;
    assign grant        = r_grant;
    assign busy         = r_busy;
    assign pkt_done_cnt = r_pkt_cnt;

    // -------------------------------------------------------------------------
    // FSM. awfull is only consulted when starting a packet; once a packet is
    // under way it is finished regardless, with wfull alone pacing it.
    // -------------------------------------------------------------------------
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_busy    <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its inputs from before the clock edge.
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_XFER;
                        r_grant <= ONE_HOT0 << w_win_idx;
                        r_owner <= w_win_idx;
                        r_busy  <= 1'b1;
                    end
                end
                ST_XFER: begin
                    // A missing beat from the owner simply holds the grant.
                    if (w_last_beat) begin
                        r_state   <= ST_IDLE;
                        r_grant   <= '0;
                        r_busy    <= 1'b0;
                        r_ptr     <= wrap_inc(r_owner);
                        r_pkt_cnt <= r_pkt_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Overflow safety: the FIFO is never written while it reports full.
    a_no_write_when_full: assert property (
        @(posedge wclk) disable iff (wrst) !(winc && wfull));

    // At most one owner at any time.
    a_grant_onehot0: assert property (
        @(posedge wclk) disable iff (wrst) $onehot0(r_grant));

    // busy and grant describe the same condition.
    a_busy_matches_grant: assert property (
        @(posedge wclk) disable iff (wrst) r_busy == (r_grant != '0));
`endif

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_async_fifo_wr_arbiter
//
// Self-checking bench for async_fifo_wr_arbiter (DSIZE=32, NREQ=4, CNTW=16).
// A behavioural 16-entry FIFO sits on the write port. A per-cycle vector table
// covers single-packet transfer, awfull gating and awfull-during-packet; short
// hand-written sequences cover round-robin order, FIFO-full stall, owner
// valid bubbles and reset in the middle of a packet.
// -----------------------------------------------------------------------------
module tb_async_fifo_wr_arbiter;

    localparam int DSIZE = 32;
    localparam int NREQ  = 4;
    localparam int CNTW  = 16;
    localparam int DEPTH = 16;
    localparam int NVEC  = 14;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic                  wfull;
    logic                  awfull;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic [CNTW-1:0]       pkt_done_cnt;

    async_fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .CNTW(CNTW)) dut (
        .wclk         (wclk),
        .wrst         (wrst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_last     (req_last),
        .winc         (winc),
        .wdata        (wdata),
        .wfull        (wfull),
        .awfull       (awfull),
        .grant        (grant),
        .busy         (busy),
        .pkt_done_cnt (pkt_done_cnt)
    );

    always #5 wclk = ~wclk;

    // ---------------------------------------------------------------- checking
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- stimulus muxing
    logic                  auto_mode;
    logic [NREQ-1:0]       t_valid, t_last;
    logic [NREQ*DSIZE-1:0] t_data;
    logic [NREQ-1:0]       a_valid, a_last;
    logic [NREQ*DSIZE-1:0] a_data;

    assign req_valid = auto_mode ? a_valid : t_valid;
    assign req_last  = auto_mode ? a_last  : t_last;
    assign req_data  = auto_mode ? a_data  : t_data;

    // Packet sources: lane k sends lane_npkts[k] packets of lane_len[k] beats.
    // Beat data = {lane, packet number, beat number}.
    int   lane_len   [NREQ];
    int   lane_npkts [NREQ];
    int   lane_cnt   [NREQ];
    logic lane_stall [NREQ];

    function automatic logic [31:0] beat_word(input int k, input int p, input int b);
        return {8'(k), 8'(p), 16'(b)};
    endfunction

    always_comb begin
        a_valid = '0;
        a_last  = '0;
        a_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            a_valid[k] = (lane_cnt[k] < lane_len[k] * lane_npkts[k]) && !lane_stall[k];
            a_last[k]  = (lane_cnt[k] % lane_len[k]) == (lane_len[k] - 1);
            a_data[k*DSIZE +: DSIZE] = beat_word(k, lane_cnt[k] / lane_len[k], lane_cnt[k] % lane_len[k]);
        end
    end

    // ---------------------------------------------------------------- FIFO model and monitors
    logic        rinc, force_af, clear;
    int          fcount;
    logic [31:0] fifo_q  [$];
    logic [31:0] wr_log  [$];
    logic [31:0] rd_log  [$];
    logic [3:0]  glog    [$];
    int          gap_log [$];
    logic [15:0] cnt_log [$];
    int          zero_run;
    logic [3:0]  prev_grant;

    assign wfull  = (fcount >= DEPTH);
    assign awfull = (fcount >= DEPTH - 1) || force_af;

    always @(posedge wclk) begin
        if (clear) begin
            fifo_q.delete();
            wr_log.delete();
            rd_log.delete();
            glog.delete();
            gap_log.delete();
            cnt_log.delete();
            fcount     <= 0;
            zero_run   <= 0;
            prev_grant <= '0;
            for (int k = 0; k < NREQ; k++) lane_cnt[k] <= 0;
        end else begin
            if (rinc && fifo_q.size() > 0) rd_log.push_back(fifo_q.pop_front());
            if (winc) begin
                check("no_write_when_full", 64'(fcount < DEPTH), 64'(1));
                fifo_q.push_back(wdata);
                wr_log.push_back(wdata);
            end
            fcount <= fcount + int'(winc) - int'(rinc && fcount > 0);
            for (int k = 0; k < NREQ; k++)
                if (auto_mode && req_valid[k] && req_ready[k]) lane_cnt[k] <= lane_cnt[k] + 1;
            if (grant != 4'b0 && prev_grant == 4'b0) begin
                glog.push_back(grant);
                gap_log.push_back(zero_run);
                cnt_log.push_back(pkt_done_cnt);
            end
            zero_run   <= (grant == 4'b0) ? zero_run + 1 : 0;
            prev_grant <= grant;
        end
    end

    // ---------------------------------------------------------------- vector table
    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        af;
        logic [3:0]  e_grant;
        logic [3:0]  e_ready;
        logic        e_winc;
        logic [31:0] e_wdata;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tv [NVEC];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                                input logic af, input logic [3:0] eg, input logic [3:0] er,
                                input logic ew, input logic [31:0] ed, input logic eb,
                                input logic [15:0] ec);
        vec_t r;
        r.valid = v;  r.last = l;     r.data = d;     r.af = af;
        r.e_grant = eg; r.e_ready = er; r.e_winc = ew; r.e_wdata = ed;
        r.e_busy = eb;  r.e_cnt = ec;
        return r;
    endfunction

    // ---------------------------------------------------------------- helpers
    task automatic do_reset();
        wrst  = 1'b1;
        clear = 1'b1;
        repeat (2) @(negedge wclk);
        wrst  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic set_lanes_idle();
        for (int k = 0; k < NREQ; k++) begin
            lane_npkts[k] = 0;
            lane_len[k]   = 1;
            lane_stall[k] = 1'b0;
        end
    endtask

    task automatic wait_grant(input string name, input logic [3:0] g, input int limit);
        int c = 0;
        while (grant !== g && c < limit) begin
            @(negedge wclk); #1;
            c++;
        end
        check(name, 64'(grant), 64'(g));
    endtask

    task automatic wait_first_grant(input string name, input logic [3:0] g, input int limit);
        int c = 0;
        while (grant === 4'b0 && c < limit) begin
            @(negedge wclk); #1;
            c++;
        end
        check(name, 64'(grant), 64'(g));
    endtask

    task automatic wait_cnt(input string name, input logic [15:0] v, input int limit);
        int c = 0;
        while (pkt_done_cnt !== v && c < limit) begin
            @(negedge wclk); #1;
            c++;
        end
        check(name, 64'(pkt_done_cnt), 64'(v));
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------------------------------------------------------- test sequence
    initial begin
        logic [31:0] exp_q [$];

        wrst = 1'b1; clear = 1'b1; auto_mode = 1'b0; rinc = 1'b0; force_af = 1'b0;
        t_valid = '1; t_last = '1; t_data = '0;
        set_lanes_idle();

        // Reset state, with every request already asserted.
        repeat (2) @(negedge wclk);
        #1;
        check("rst grant", 64'(grant), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst cnt", 64'(pkt_done_cnt), 64'(0));
        check("rst ready", 64'(req_ready), 64'(0));
        check("rst winc", 64'(winc), 64'(0));
        check("rst wdata", 64'(wdata), 64'(0));
        t_valid = '0; t_last = '0;
        do_reset();

        // Table: 3-beat packet on requester 1, awfull gating of requester 2,
        // awfull rising during a packet from requester 0.
        tv[0]  = mk(4'b0010, 4'b0000, 32'hA,  1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,  1'b0, 16'd0);
        tv[1]  = mk(4'b0010, 4'b0000, 32'hA,  1'b0, 4'b0010, 4'b0010, 1'b1, 32'hA,  1'b1, 16'd0);
        tv[2]  = mk(4'b0010, 4'b0000, 32'hB,  1'b0, 4'b0010, 4'b0010, 1'b1, 32'hB,  1'b1, 16'd0);
        tv[3]  = mk(4'b0010, 4'b0010, 32'hC,  1'b0, 4'b0010, 4'b0010, 1'b1, 32'hC,  1'b1, 16'd0);
        tv[4]  = mk(4'b0000, 4'b0000, 32'h0,  1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,  1'b0, 16'd1);
        tv[5]  = mk(4'b0100, 4'b0100, 32'h44, 1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0,  1'b0, 16'd1);
        tv[6]  = mk(4'b0100, 4'b0100, 32'h44, 1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0,  1'b0, 16'd1);
        tv[7]  = mk(4'b0100, 4'b0100, 32'h44, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,  1'b0, 16'd1);
        tv[8]  = mk(4'b0100, 4'b0100, 32'h44, 1'b0, 4'b0100, 4'b0100, 1'b1, 32'h44, 1'b1, 16'd1);
        tv[9]  = mk(4'b0000, 4'b0000, 32'h0,  1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,  1'b0, 16'd2);
        tv[10] = mk(4'b0001, 4'b0000, 32'h51, 1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,  1'b0, 16'd2);
        tv[11] = mk(4'b0001, 4'b0000, 32'h51, 1'b1, 4'b0001, 4'b0001, 1'b1, 32'h51, 1'b1, 16'd2);
        tv[12] = mk(4'b0001, 4'b0001, 32'h52, 1'b1, 4'b0001, 4'b0001, 1'b1, 32'h52, 1'b1, 16'd2);
        tv[13] = mk(4'b0000, 4'b0000, 32'h0,  1'b0, 4'b0000, 4'b0000, 1'b0, 32'h0,  1'b0, 16'd3);

        rinc = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            @(negedge wclk);
            t_valid  = tv[i].valid;
            t_last   = tv[i].last;
            force_af = tv[i].af;
            for (int k = 0; k < NREQ; k++)
                t_data[k*DSIZE +: DSIZE] = tv[i].valid[k] ? tv[i].data : (32'hDEAD_0000 | 32'(k));
            #1;
            check($sformatf("vec%0d grant", i), 64'(grant),        64'(tv[i].e_grant));
            check($sformatf("vec%0d ready", i), 64'(req_ready),    64'(tv[i].e_ready));
            check($sformatf("vec%0d winc", i),  64'(winc),         64'(tv[i].e_winc));
            check($sformatf("vec%0d wdata", i), 64'(wdata),        64'(tv[i].e_wdata));
            check($sformatf("vec%0d busy", i),  64'(busy),         64'(tv[i].e_busy));
            check($sformatf("vec%0d cnt", i),   64'(pkt_done_cnt), 64'(tv[i].e_cnt));
        end
        force_af = 1'b0;
        repeat (3) @(negedge wclk);
        exp_q = '{32'hA, 32'hB, 32'hC, 32'h44, 32'h51, 32'h52};
        check("tbl wr count", 64'(wr_log.size()), 64'(exp_q.size()));
        check("tbl rd count", 64'(rd_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
            check($sformatf("tbl wr[%0d]", i), 64'(wr_log[i]), 64'(exp_q[i]));
        for (int i = 0; i < 3 && i < rd_log.size(); i++)
            check($sformatf("tbl rd[%0d]", i), 64'(rd_log[i]), 64'(exp_q[i]));

        // Round robin: all four requesters valid from reset, 2-beat packets,
        // requester 0 has a second packet.
        set_lanes_idle();
        for (int k = 0; k < NREQ; k++) begin
            lane_len[k]   = 2;
            lane_npkts[k] = (k == 0) ? 2 : 1;
        end
        auto_mode = 1'b1;
        do_reset();
        wait_cnt("rr done", 16'd5, 100);
        repeat (2) @(negedge wclk);
        exp_q = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
        check("rr grant count", 64'(glog.size()), 64'(5));
        for (int i = 0; i < 5 && i < glog.size(); i++)
            check($sformatf("rr grant[%0d]", i), 64'(glog[i]), 64'(exp_q[i]));
        for (int i = 1; i < 5 && i < gap_log.size(); i++)
            check($sformatf("rr gap[%0d]", i), 64'(gap_log[i]), 64'(1));
        if (cnt_log.size() == 5) check("rr cnt at 5th grant", 64'(cnt_log[4]), 64'(4));
        exp_q = '{beat_word(0, 0, 0), beat_word(0, 0, 1), beat_word(1, 0, 0), beat_word(1, 0, 1),
                  beat_word(2, 0, 0), beat_word(2, 0, 1), beat_word(3, 0, 0), beat_word(3, 0, 1),
                  beat_word(0, 1, 0), beat_word(0, 1, 1)};
        check("rr wr count", 64'(wr_log.size()), 64'(10));
        for (int i = 0; i < 10 && i < wr_log.size(); i++)
            check($sformatf("rr wr[%0d]", i), 64'(wr_log[i]), 64'(exp_q[i]));

        // FIFO full: 20-beat packet into a 16-deep FIFO with no reads.
        set_lanes_idle();
        lane_len[0] = 20; lane_npkts[0] = 1;
        rinc = 1'b0;
        do_reset();
        begin
            int c = 0;
            while (!wfull && c < 60) begin
                @(negedge wclk); #1;
                c++;
            end
        end
        check("full reached", 64'(wfull), 64'(1));
        check("full wr count", 64'(wr_log.size()), 64'(16));
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("full stall%0d winc", i),  64'(winc),      64'(0));
            check($sformatf("full stall%0d ready", i), 64'(req_ready), 64'(0));
            check($sformatf("full stall%0d grant", i), 64'(grant),     64'(4'b0001));
            @(negedge wclk);
        end
        rinc = 1'b1;
        repeat (4) @(negedge wclk);
        rinc = 1'b0;
        wait_cnt("full done", 16'd1, 50);
        @(negedge wclk); #1;
        check("full busy after", 64'(busy), 64'(0));
        check("full fifo level", 64'(fcount), 64'(16));
        check("full wr total", 64'(wr_log.size()), 64'(20));
        for (int i = 0; i < 20 && i < wr_log.size(); i++)
            check($sformatf("full wr[%0d]", i), 64'(wr_log[i]), 64'(beat_word(0, 0, i)));
        check("full rd count", 64'(rd_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            check($sformatf("full rd[%0d]", i), 64'(rd_log[i]), 64'(beat_word(0, 0, i)));

        // Owner bubble: requester 3 drops valid mid-packet while 1 waits.
        set_lanes_idle();
        lane_len[3] = 4; lane_npkts[3] = 1;
        lane_len[1] = 2;
        rinc = 1'b1;
        do_reset();
        wait_grant("bub grant3", 4'b1000, 10);
        @(negedge wclk);
        lane_stall[3] = 1'b1;
        lane_npkts[1] = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bub%0d grant", i), 64'(grant),     64'(4'b1000));
            check($sformatf("bub%0d winc", i),  64'(winc),      64'(0));
            check($sformatf("bub%0d ready", i), 64'(req_ready), 64'(4'b1000));
            check($sformatf("bub%0d busy", i),  64'(busy),      64'(1));
            @(negedge wclk);
        end
        lane_stall[3] = 1'b0;
        wait_cnt("bub done", 16'd2, 30);
        check("bub grant count", 64'(glog.size()), 64'(2));
        if (glog.size() == 2) check("bub second owner", 64'(glog[1]), 64'(4'b0010));
        exp_q = '{beat_word(3, 0, 0), beat_word(3, 0, 1), beat_word(3, 0, 2), beat_word(3, 0, 3),
                  beat_word(1, 0, 0), beat_word(1, 0, 1)};
        check("bub wr count", 64'(wr_log.size()), 64'(6));
        for (int i = 0; i < 6 && i < wr_log.size(); i++)
            check($sformatf("bub wr[%0d]", i), 64'(wr_log[i]), 64'(exp_q[i]));

        // Reset during beat 2 of a 5-beat packet; pointer was left at 2.
        set_lanes_idle();
        @(negedge wclk);
        clear = 1'b1;
        @(negedge wclk);
        clear = 1'b0;
        lane_len[0] = 5; lane_npkts[0] = 1;
        wait_grant("mid grant0", 4'b0001, 10);
        @(negedge wclk);
        #1;
        wrst = 1'b1;
        #1;
        check("mid rst grant", 64'(grant),        64'(0));
        check("mid rst winc",  64'(winc),         64'(0));
        check("mid rst busy",  64'(busy),         64'(0));
        check("mid rst ready", 64'(req_ready),    64'(0));
        check("mid rst cnt",   64'(pkt_done_cnt), 64'(0));
        check("mid rst wdata", 64'(wdata),        64'(0));
        check("mid partial",   64'(wr_log.size()), 64'(1));
        set_lanes_idle();
        clear = 1'b1;
        repeat (2) @(negedge wclk);
        lane_len[0] = 2; lane_npkts[0] = 1;
        lane_len[2] = 2; lane_npkts[2] = 1;
        clear = 1'b0;
        wrst  = 1'b0;
        wait_first_grant("mid first after rst", 4'b0001, 10);
        wait_cnt("mid done", 16'd2, 20);
        if (glog.size() == 2) check("mid second owner", 64'(glog[1]), 64'(4'b0100));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
